filter_sched: RTL
=================

# filter_sched

Round-robin scheduler that time-shares one `filter` datapath instance between `NR_CH` independent sample streams. Sits between the per-channel stream sources/sinks and the filter: it answers the filter's req/ack input and output handshakes, selects each channel's coefficient set onto `h_in`, and returns each result tagged with its originating channel. Exactly one sample pair is in flight in the filter at any time.

## Interface
- `NR_CH`, 4: number of channels; a power of two, at least 2.
- `NR_STAGES`, 32: filter taps. Passed through to size `CWIDTH`.
- `DWIDTH`, 16: sample width.
- `DDWIDTH`, 2*DWIDTH: sample-pair width.
- `CWIDTH`, NR_STAGES*DWIDTH: width of one coefficient set.
- `CHW`, log2(NR_CH): width of a channel index.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ch_in_valid` in NR_CH: channel c has a sample pair pending.
- `ch_in_ready` out NR_CH: one-hot accept. A transfer happens when `valid[c]` and `ready[c]` are both high.
- `ch_in_data` in NR_CH*DDWIDTH: channel c occupies bits [c*DDWIDTH +: DDWIDTH].
- `ch_coef` in NR_CH*CWIDTH: per-channel coefficient sets, same slicing.
- `out_valid` out 1: result available.
- `out_ready` in 1: sink accepts the result.
- `out_data` out DDWIDTH: filtered sample pair.
- `out_ch` out CHW: channel index of `out_data`.
- `f_req_in` in 1: filter's `req_in`.
- `f_ack_in` out 1: drives filter's `ack_in`.
- `f_data_in` out DDWIDTH: drives filter's `data_in`.
- `f_req_out` in 1: filter's `req_out`.
- `f_ack_out` out 1: drives filter's `ack_out`.
- `f_data_out` in DDWIDTH: filter's `data_out`.
- `f_h_in` out CWIDTH: drives filter's `h_in`.

## Operation
- State machine states: IDLE, FEED, WAIT_OUT, DRAIN.
- **IDLE**
  - When `f_req_in`=1 and any `ch_in_valid` is set, grant channel g, the first valid channel at or after pointer `rr`, searching cyclically.
  - `ch_in_ready[g]`=1 combinationally in that cycle. All other ready bits are 0.
  - On the edge: `f_data_in`<=slice g, `cur_ch`<=g, `f_ack_in`<=1, go to FEED.
- **FEED**
  - `f_ack_in` is high for exactly this one cycle.
  - On the edge: `f_ack_in`<=0, go to WAIT_OUT.
- **WAIT_OUT**
  - When `f_req_out`=1, on the edge: `out_data`<=`f_data_out`, `out_ch`<=`cur_ch`, `out_valid`<=1, `f_ack_out`<=1, go to DRAIN.
- **DRAIN**
  - `f_ack_out` is cleared after one cycle.
  - When `out_valid`=1 and `out_ready`=1: clear `out_valid`, set `rr`<=`cur_ch`+1 (mod NR_CH), go to IDLE.
  - The exit from DRAIN must not happen earlier than the cycle after `f_ack_out` drops.
- `f_h_in` is always slice `cur_ch` of `ch_coef`. It is stable from FEED until the result is captured.
- `f_data_in` holds its last value outside FEED.
- `ch_in_ready` is all-zero in every state except IDLE.
- `f_ack_in` and `f_ack_out` are never high at the same time. Both are low whenever the state is IDLE, so the filter's all-low re-arm condition is met.
- Reset may be asserted mid-operation in any state. It clears everything immediately; an in-flight sample is discarded. The filter must be reset by the same reset.
- Reset values:
  - state IDLE, `rr`=0, `cur_ch`=0
  - `f_ack_in`=0, `f_ack_out`=0, `f_data_in`=0
  - `out_valid`=0, `out_data`=0, `out_ch`=0
  - `ch_in_ready`=0

## Timing
- Accept in cycle 0 gives:
  - `f_ack_in` high in cycle 1.
  - Filter `req_out` high in cycle 2.
  - `out_valid` and `f_ack_out` high in cycle 3.
- Filter `req_out` drops in cycle 4, and `f_req_in` returns in cycle 5 at the earliest.
- Peak throughput is one pair per 5 cycles with `out_ready` held at 1.
- Output backpressure (`out_ready`=0) holds DRAIN indefinitely. No new input is accepted during that time.
- `f_req_in` high with no channel valid: stay in IDLE with no grant.
- A channel that drops valid before it is granted is simply skipped.
- Fairness: each continuously valid channel is served within NR_CH grants.

## Structure
- Shared package `filter_pkg` holds:
  - the state enum;
  - the default `DWIDTH`/`NR_STAGES` constants used by both `filter` and this block;
  - a `clog2` helper.
- One sub-module, `rr_pick`: a combinational cyclic priority encoder taking (request vector, pointer) and returning (grant index, any).
- The FSM, registers and slicing muxes stay in `filter_sched`.
- The bench instantiates `filter` + `filter_sched`.

## Test plan
- Single channel: `ch_in_valid`=0001, data 0x0001_0002 → `out_valid` rises 3 cycles after accept, with `out_data`=0x0001_0002 and `out_ch`=0.
- All four channels continuously valid, data 0x000c_000c on channel c, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0,… and one result every 5 cycles.
- Pointer wrap: `rr`=3 with only channels 1 and 3 valid → 3 is granted, then 1.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid`/`out_data` stable, `ch_in_ready`=0 throughout, `f_ack_out` a single-cycle pulse.
- Protocol checks: `f_ack_in` and `f_ack_out` never high together; each pulse lasts exactly 1 cycle; `f_h_in` equals the granted channel's set while that channel is in flight.
- Reset mid-operation: drop `rst` while in WAIT_OUT → all outputs at reset values immediately; after release, the first grant goes to channel 0 and the returned data is correct.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the filter datapath and its round-robin channel scheduler.
package filter_pkg;
  localparam int unsigned DWIDTH_DEF    = 16;
  localparam int unsigned NR_STAGES_DEF = 32;

  typedef enum logic [1:0] {IDLE, FEED, WAIT_OUT, DRAIN} sched_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/filter_sched_if.sv
// Req/ack link between the scheduler (master) and the shared filter datapath (slave).
interface filter_sched_if
  import filter_pkg::*;
#(
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned NR_STAGES = NR_STAGES_DEF
);
  logic                        req_in;
  logic                        ack_in;
  logic [2*DWIDTH-1:0]         data_in;
  logic                        req_out;
  logic                        ack_out;
  logic [2*DWIDTH-1:0]         data_out;
  logic [NR_STAGES*DWIDTH-1:0] h_in;

  modport master (
    input  req_in, req_out, data_out,
    output ack_in, data_in, ack_out, h_in
  );

  modport slave (
    output req_in, req_out, data_out,
    input  ack_in, data_in, ack_out, h_in
  );
endinterface

// File: rtl/filter.sv
// Single-sample filter datapath: both lanes are offset by the sum of all taps.
// Re-arms req_in only once both acks are low.
module filter
  import filter_pkg::*;
#(
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned NR_STAGES = NR_STAGES_DEF
)(
  input  logic           clk,
  input  logic           rst,
  filter_sched_if.slave  f
);
  logic [DWIDTH-1:0] tap_sum;

  always_comb begin
    tap_sum = '0;
    for (int unsigned k = 0; k < NR_STAGES; k++)
      tap_sum = tap_sum + f.h_in[k*DWIDTH +: DWIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f.req_in   <= 1'b0;
      f.req_out  <= 1'b0;
      f.data_out <= '0;
    end else if (f.req_in && f.ack_in) begin
      f.req_in   <= 1'b0;
      f.req_out  <= 1'b1;
      f.data_out <= {f.data_in[2*DWIDTH-1:DWIDTH] + tap_sum,
                     f.data_in[DWIDTH-1:0] + tap_sum};
    end else if (f.req_out && f.ack_out) begin
      f.req_out <= 1'b0;
    end else if (!f.req_in && !f.req_out && !f.ack_in && !f.ack_out) begin
      f.req_in <= 1'b1;
    end
  end
endmodule

// File: rtl/filter_sched_rr_pick.sv
// Cyclic priority encoder: first set request at or after ptr, wrapping around.
module rr_pick
  import filter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = clog2(N)
)(
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);
  logic [W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/filter_sched.sv
// Round-robin scheduler time-sharing one filter between NR_CH sample streams,
// with at most one sample pair in flight.
module filter_sched
  import filter_pkg::*;
#(
  parameter int unsigned NR_CH     = 4,
  parameter int unsigned NR_STAGES = NR_STAGES_DEF,
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned DDWIDTH   = 2 * DWIDTH,
  parameter int unsigned CWIDTH    = NR_STAGES * DWIDTH,
  parameter int unsigned CHW       = clog2(NR_CH)
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_CH-1:0]          ch_in_valid,
  output logic [NR_CH-1:0]          ch_in_ready,
  input  logic [NR_CH*DDWIDTH-1:0]  ch_in_data,
  input  logic [NR_CH*CWIDTH-1:0]   ch_coef,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DDWIDTH-1:0]        out_data,
  output logic [CHW-1:0]            out_ch,
  filter_sched_if.master            f
);
  sched_state_t   state;
  logic [CHW-1:0] rr;
  logic [CHW-1:0] cur_ch;
  logic [CHW-1:0] grant;
  logic           any;
  logic           take;

  rr_pick #(.N(NR_CH), .W(CHW)) u_pick (
    .req   (ch_in_valid),
    .ptr   (rr),
    .grant (grant),
    .any   (any)
  );

  assign take   = (state == IDLE) && f.req_in && any;
  assign f.h_in = ch_coef[cur_ch*CWIDTH +: CWIDTH];

  always_comb begin
    ch_in_ready = '0;
    if (take) ch_in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr        <= '0;
      cur_ch    <= '0;
      f.ack_in  <= 1'b0;
      f.ack_out <= 1'b0;
      f.data_in <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          f.data_in <= ch_in_data[grant*DDWIDTH +: DDWIDTH];
          cur_ch    <= grant;
          f.ack_in  <= 1'b1;
          state     <= FEED;
        end
        FEED: begin
          f.ack_in <= 1'b0;
          state    <= WAIT_OUT;
        end
        WAIT_OUT: if (f.req_out) begin
          out_data  <= f.data_out;
          out_ch    <= cur_ch;
          out_valid <= 1'b1;
          f.ack_out <= 1'b1;
          state     <= DRAIN;
        end
        DRAIN: begin
          // The result handshake may complete while f.ack_out is still high;
          // out_valid drops then so it is never presented twice, and the exit
          // waits for the cycle after f.ack_out has fallen.
          f.ack_out <= 1'b0;
          if (out_valid && out_ready) out_valid <= 1'b0;
          if ((!out_valid || out_ready) && !f.ack_out) begin
            rr    <= cur_ch + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
